// File: rtl/crypto_stream_adapter.sv
// Packs four 32-bit ingress words into a 128-bit block, runs it through an external
// crypto engine and streams the 128-bit result back out as four 32-bit words.
module crypto_stream_adapter #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  s_tdata,
   input  logic         s_tvalid,
   input  logic         s_tlast,
   output logic         s_tready,
   output logic [31:0]  m_tdata,
   output logic         m_tvalid,
   output logic         m_tlast,
   input  logic         m_tready,
   output logic         eng_start,
   output logic [127:0] eng_din,
   input  logic         eng_busy,
   input  logic         eng_done,
   input  logic [127:0] eng_dout,
   output logic         err_timeout,
   output logic [15:0]  blk_cnt
);

   typedef enum logic [1:0] {StFill, StStart, StWait, StDrain} state_e;

   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

   state_e        state_q, state_d;
   logic [127:0]  din_q, din_d;
   logic [127:0]  buf_q, buf_d;
   logic [1:0]    wcnt_q, wcnt_d;
   logic [1:0]    dcnt_q, dcnt_d;
   logic          blk_last_q, blk_last_d;
   logic          err_q, err_d;
   logic [15:0]   tcnt_q, tcnt_d;
   logic [15:0]   blk_cnt_q, blk_cnt_d;

   // Word 0 sits in the most significant slot, so the bit offset is (3 - index) * 32.
   logic [6:0]    wsel, dsel;
   assign wsel = {~wcnt_q, 5'd0};
   assign dsel = {~dcnt_q, 5'd0};

   always_comb begin
      state_d    = state_q;
      din_d      = din_q;
      buf_d      = buf_q;
      wcnt_d     = wcnt_q;
      dcnt_d     = dcnt_q;
      blk_last_d = blk_last_q;
      err_d      = err_q;
      tcnt_d     = tcnt_q;
      blk_cnt_d  = blk_cnt_q;
      s_tready   = 1'b0;
      m_tvalid   = 1'b0;
      m_tlast    = 1'b0;
      m_tdata    = '0;
      eng_start  = 1'b0;

      unique case (state_q)
         StFill: begin
            s_tready = 1'b1;
            if (s_tvalid) begin
               din_d[wsel +: 32] = s_tdata;
               if (wcnt_q == 2'd3 || s_tlast) begin
                  state_d    = StStart;
                  wcnt_d     = '0;
                  blk_last_d = s_tlast;
               end else begin
                  wcnt_d = wcnt_q + 2'd1;
               end
            end
         end
         StStart: begin
            if (!eng_busy) begin
               eng_start = 1'b1;
               state_d   = StWait;
               tcnt_d    = '0;
            end
         end
         StWait: begin
            // A result arriving in the final allowed cycle takes priority over the abort.
            if (eng_done) begin
               buf_d   = eng_dout;
               dcnt_d  = '0;
               state_d = StDrain;
            end else if (tcnt_q == TimeoutLast) begin
               err_d   = 1'b1;
               din_d   = '0;
               tcnt_d  = '0;
               state_d = StFill;
            end else begin
               tcnt_d = tcnt_q + 16'd1;
            end
         end
         StDrain: begin
            m_tvalid = 1'b1;
            m_tdata  = buf_q[dsel +: 32];
            m_tlast  = (dcnt_q == 2'd3) && blk_last_q;
            if (m_tready) begin
               if (dcnt_q == 2'd3) begin
                  dcnt_d    = '0;
                  din_d     = '0;
                  blk_cnt_d = blk_cnt_q + 16'd1;
                  state_d   = StFill;
               end else begin
                  dcnt_d = dcnt_q + 2'd1;
               end
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StFill;
         din_q      <= '0;
         buf_q      <= '0;
         wcnt_q     <= '0;
         dcnt_q     <= '0;
         blk_last_q <= 1'b0;
         err_q      <= 1'b0;
         tcnt_q     <= '0;
         blk_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         din_q      <= din_d;
         buf_q      <= buf_d;
         wcnt_q     <= wcnt_d;
         dcnt_q     <= dcnt_d;
         blk_last_q <= blk_last_d;
         err_q      <= err_d;
         tcnt_q     <= tcnt_d;
         blk_cnt_q  <= blk_cnt_d;
      end
   end

   assign eng_din     = din_q;
   assign err_timeout = err_q;
   assign blk_cnt     = blk_cnt_q;

endmodule

// File: tb/tb_crypto_stream_adapter.sv
// Bench for crypto_stream_adapter: vector table of blocks with an egress scoreboard,
// plus hand sequences for engine timeout and reset in the middle of a drain.
module tb_crypto_stream_adapter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  s_tdata = '0;
   logic         s_tvalid = 1'b0;
   logic         s_tlast = 1'b0;
   logic         s_tready;
   logic [31:0]  m_tdata;
   logic         m_tvalid;
   logic         m_tlast;
   logic         m_tready = 1'b1;
   logic         eng_start;
   logic [127:0] eng_din;
   logic         eng_busy = 1'b0;
   logic         eng_done = 1'b0;
   logic [127:0] eng_dout = '0;
   logic         err_timeout;
   logic [15:0]  blk_cnt;

   crypto_stream_adapter #(.TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tlast     (s_tlast),
      .s_tready    (s_tready),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tlast     (m_tlast),
      .m_tready    (m_tready),
      .eng_start   (eng_start),
      .eng_din     (eng_din),
      .eng_busy    (eng_busy),
      .eng_done    (eng_done),
      .eng_dout    (eng_dout),
      .err_timeout (err_timeout),
      .blk_cnt     (blk_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           n;
      logic         last;
      logic [127:0] words;
      logic [127:0] dout;
      logic [127:0] din;
      int           busy;
      logic         tog;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic        l;
   } exp_t;

   exp_t         q[$];
   vec_t         vecs[5];
   int           checks = 0;
   int           errors = 0;
   int           start_cnt = 0;
   int           exp_blk = 0;
   logic         tog = 1'b0;
   logic         stall = 1'b0;
   logic [31:0]  hold = '0;
   logic         saw_start = 1'b0;
   logic         rdy_s = 1'b0;
   logic [127:0] din_s = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: sample and score at the falling edge, then step past the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      saw_start = eng_start;
      rdy_s     = s_tready;
      din_s     = eng_din;
      if (eng_start) start_cnt++;
      if (m_tvalid) begin
         if (stall) chk("stall_hold", {96'd0, m_tdata}, {96'd0, hold});
         if (m_tready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_egress: got %h expected none", m_tdata);
            end else begin
               e = q.pop_front();
               chk("m_tdata", {96'd0, m_tdata}, {96'd0, e.d});
               chk("m_tlast", {127'd0, m_tlast}, {127'd0, e.l});
            end
            stall = 1'b0;
         end else begin
            stall = 1'b1;
            hold  = m_tdata;
         end
      end else begin
         stall = 1'b0;
      end
      @(posedge clk);
      #1;
      m_tready = tog ? ~m_tready : 1'b1;
   endtask

   task automatic send(input vec_t v, input bit push);
      exp_t e;
      for (int i = 0; i < v.n; i++) begin
         s_tdata  = v.words[(3 - i) * 32 +: 32];
         s_tvalid = 1'b1;
         s_tlast  = v.last && (i == v.n - 1);
         tick();
         chk("s_tready", {127'd0, rdy_s}, 128'd1);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if (push) begin
         for (int j = 0; j < 4; j++) begin
            e.d = v.dout[(3 - j) * 32 +: 32];
            e.l = v.last && (j == 3);
            q.push_back(e);
         end
      end
   endtask

   task automatic wait_start(input logic [127:0] din);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!saw_start && n < 50);
      chk("eng_start_seen", {127'd0, saw_start}, 128'd1);
      chk("eng_din", din_s, din);
   endtask

   task automatic respond(input logic [127:0] dout);
      repeat (2) tick();
      eng_done = 1'b1;
      eng_dout = dout;
      tick();
      eng_done = 1'b0;
      eng_dout = '0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_done_left", 128'(q.size()), 128'd0);
      q.delete();
   endtask

   task automatic run_block(input vec_t v);
      int base = start_cnt;
      eng_busy = (v.busy > 0);
      tog      = v.tog;
      send(v, 1'b1);
      if (v.busy > 0) begin
         repeat (v.busy) tick();
         chk("start_held_off", 128'(start_cnt - base), 128'd0);
         eng_busy = 1'b0;
      end
      wait_start(v.din);
      respond(v.dout);
      wait_drain();
      tog = 1'b0;
      chk("start_pulses", 128'(start_cnt - base), 128'd1);
      exp_blk++;
      chk("blk_cnt", {112'd0, blk_cnt}, 128'(exp_blk));
   endtask

   initial begin
      int n;
      vecs[0] = '{4, 1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, {4{32'hA5A5A5A5}},
                  128'h00112233_44556677_8899AABB_CCDDEEFF, 0, 1'b0};
      vecs[1] = '{2, 1'b1, 128'h11111111_22222222_33333333_44444444,
                  128'h0BADF00D_13579BDF_2468ACE0_FFFF0000,
                  128'h11111111_22222222_00000000_00000000, 0, 1'b0};
      vecs[2] = '{4, 1'b0, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98,
                  128'h10203040_50607080_90A0B0C0_D0E0F000,
                  128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 10, 1'b0};
      vecs[3] = '{1, 1'b1, 128'hCAFEF00D_AAAAAAAA_BBBBBBBB_CCCCCCCC,
                  128'h01010101_02020202_03030303_04040404,
                  128'hCAFEF00D_00000000_00000000_00000000, 0, 1'b1};
      vecs[4] = '{3, 1'b1, 128'h12345678_9ABCDEF0_0FEDCBA9_99999999,
                  128'h55555555_66666666_77777777_88888888,
                  128'h12345678_9ABCDEF0_0FEDCBA9_00000000, 3, 1'b1};

      #2;
      chk("rst_m_tvalid", {127'd0, m_tvalid}, 128'd0);
      chk("rst_m_tlast", {127'd0, m_tlast}, 128'd0);
      chk("rst_m_tdata", {96'd0, m_tdata}, 128'd0);
      chk("rst_eng_start", {127'd0, eng_start}, 128'd0);
      chk("rst_eng_din", eng_din, 128'd0);
      chk("rst_err", {127'd0, err_timeout}, 128'd0);
      chk("rst_blk_cnt", {112'd0, blk_cnt}, 128'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("rst_s_tready", {127'd0, s_tready}, 128'd1);

      for (int i = 0; i < 5; i++) run_block(vecs[i]);

      // Engine never answers: abort after exactly 8 wait cycles.
      send(vecs[0], 1'b0);
      wait_start(vecs[0].din);
      repeat (7) tick();
      chk("timeout_early", {127'd0, err_timeout}, 128'd0);
      tick();
      chk("timeout_err", {127'd0, err_timeout}, 128'd1);
      chk("timeout_ready", {127'd0, s_tready}, 128'd1);
      chk("timeout_blk_cnt", {112'd0, blk_cnt}, 128'(exp_blk));
      chk("timeout_din_clr", eng_din, 128'd0);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      repeat (2) tick();
      chk("timeout_sticky", {127'd0, err_timeout}, 128'd1);
      chk("stray_done_ignored", {127'd0, m_tvalid}, 128'd0);
      run_block(vecs[1]);

      // Reset while the drain is stalled halfway through.
      tog = 1'b1;
      send(vecs[0], 1'b1);
      wait_start(vecs[0].din);
      respond(vecs[0].dout);
      n = 0;
      while (q.size() > 2 && n < 100) begin
         tick();
         n++;
      end
      chk("mid_drain_reached", 128'(q.size()), 128'd2);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_m_tvalid", {127'd0, m_tvalid}, 128'd0);
      chk("mid_rst_blk_cnt", {112'd0, blk_cnt}, 128'd0);
      chk("mid_rst_err", {127'd0, err_timeout}, 128'd0);
      chk("mid_rst_m_tdata", {96'd0, m_tdata}, 128'd0);
      q.delete();
      tog   = 1'b0;
      stall = 1'b0;
      exp_blk = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      eng_done = 1'b1;
      eng_dout = {4{32'hDEADDEAD}};
      tick();
      eng_done = 1'b0;
      tick();
      chk("post_rst_done_ignored", {127'd0, m_tvalid}, 128'd0);
      chk("post_rst_ready", {127'd0, s_tready}, 128'd1);
      run_block(vecs[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
